alu_issue_seq: RTL and testbench

- Sequential issuer and collector for the datapath ALU (4-bit op code, 32-bit A/B in; 32-bit result and zero flag out).
- Accepts an operation request from the control path via valid/ready and decodes the main-control ALUOp plus funct into the ALU op code.
- Drives the ALU with registered operands, waits the per-op latency (multi-cycle for divide), then captures the result and zero flag and presents them on an output valid/ready handshake.

---
 rtl/alu_issue_seq.sv | 132 +++++++++++++
 tb/tb_alu_issue_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Sequential ALU issuer/collector: decode, issue, wait, capture, hand off.
// Optional ALU_ISSUE_DIV0_FLAG_EN adds a div0 output and fast divide-by-zero.
module alu_issue_seq #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop_in,
    input  logic [5:0]       funct_in,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_ISSUE_DIV0_FLAG_EN
    output logic             illegal,
    output logic             div0
`else
    output logic             illegal
`endif
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1010;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    dec_op;
    logic          dec_ill;
    logic          dec_wait;

    always_comb begin
        dec_op  = OP_AND;
        dec_ill = 1'b0;
        unique case (aluop_in)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct_in)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b011010: dec_op = OP_DIV;
                    default:   dec_ill = 1'b1;
                endcase
            end
            2'b11: dec_ill = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_DIV0_FLAG_EN
    logic dec_div0;
    assign dec_div0 = (dec_op == OP_DIV) && (opnd_b == '0);
    // Divide by zero is flagged up front, so there is nothing to wait for.
    assign dec_wait = (dec_op == OP_DIV) && !dec_div0;
`else
    assign dec_wait = (dec_op == OP_DIV);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
            div0    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a   <= opnd_a;
                        alu_b   <= opnd_b;
                        alu_op  <= dec_op;
                        illegal <= dec_ill;
                        cnt     <= dec_wait ? CNT_DIV : '0;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
                        div0    <= dec_div0;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result <= illegal ? '0 : alu_result;
                        zero   <= illegal ? 1'b0 : alu_zero;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized self-checking bench for alu_issue_seq.
// Honors ALU_ISSUE_DIV0_FLAG_EN when it is defined for the build.
module tb_alu_issue_seq;

    localparam int DIV_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop_in;
    logic [5:0]  funct_in;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
    logic        div0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.WIDTH(32), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .aluop_in(aluop_in),
        .funct_in(funct_in),
        .opnd_a(opnd_a),
        .opnd_b(opnd_b),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_zero(alu_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
`ifdef ALU_ISSUE_DIV0_FLAG_EN
        .illegal(illegal),
        .div0(div0)
`else
        .illegal(illegal)
`endif
    );

    // Stand-in datapath ALU driven by the issued op code.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            4'b1010: alu_result = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: R-type funct table and its meaning.
    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h1a};
    logic [3:0] op_tab [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'ha};
    string      nm_tab [6] = '{"add", "sub", "and", "or", "slt", "div"};

    task automatic ref_model(input logic [1:0] aop, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [3:0] eop, output logic eill,
                             output logic [31:0] eres, output int elat,
                             output logic ediv0);
        string nm;
        nm    = "";
        eop   = 4'h0;
        eill  = 1'b1;
        ediv0 = 1'b0;
        if (aop == 2'b00) nm = "add";
        else if (aop == 2'b01) nm = "sub";
        else if (aop == 2'b10)
            foreach (fn_tab[i]) if (fn_tab[i] == fn) nm = nm_tab[i];
        foreach (nm_tab[i]) if (nm_tab[i] == nm) begin
            eop  = op_tab[i];
            eill = 1'b0;
        end
        eres = 32'h0;
        elat = 1;
        if (nm == "add") eres = a + b;
        if (nm == "sub") eres = a - b;
        if (nm == "and") eres = a & b;
        if (nm == "or")  eres = a | b;
        if (nm == "slt") eres = (int'(a) < int'(b)) ? 1 : 0;
        if (nm == "div") begin
            eres = (b == 0) ? 32'hFFFF_FFFF : a / b;
            elat = DIV_CYCLES;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
            if (b == 0) begin
                elat  = 1;
                ediv0 = 1'b1;
            end
`endif
        end
    endtask

    task automatic run_req(input logic [1:0] aop, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           input int hold);
        logic [3:0]  eop;
        logic        eill;
        logic [31:0] eres;
        logic        ediv0;
        int          elat;
        int          lat;
        ref_model(aop, fn, a, b, eop, eill, eres, elat, ediv0);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        aluop_in = aop;
        funct_in = fn;
        opnd_a   = a;
        opnd_b   = b;
        @(negedge clk);
        in_valid = 1'($urandom);
        aluop_in = 2'($urandom);
        funct_in = 6'($urandom);
        opnd_a   = $urandom;
        opnd_b   = $urandom;
        check("alu_op", alu_op, eop);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, elat);
        check("result", result, eill ? 32'h0 : eres);
        check("zero", zero, eill ? 1'b0 : (eres == 0));
        check("illegal", illegal, eill);
`ifdef ALU_ISSUE_DIV0_FLAG_EN
        check("div0", div0, ediv0);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            opnd_a   = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, eill ? 32'h0 : eres);
            check("hold_ready", in_ready, 0);
            check("hold_alu_a", alu_a, a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    task automatic reset_abort();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        aluop_in = 2'b10;
        funct_in = 6'b011010;
        opnd_a   = 100;
        opnd_b   = 7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
    endtask

    initial begin
        logic [1:0]  aop;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop_in  = 2'b00;
        funct_in  = 6'h0;
        opnd_a    = 32'h0;
        opnd_b    = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_illegal", illegal, 0);
`ifdef ALU_ISSUE_DIV0_FLAG_EN
        check("reset_div0", div0, 0);
`endif
        rst_n = 1'b1;

        run_req(2'b10, 6'b100000, 5, 7, 0);
        run_req(2'b01, 6'h3f, 9, 9, 0);
        run_req(2'b10, 6'b011010, 100, 7, 0);
        run_req(2'b10, 6'b100000, 1, 2, 5);
        run_req(2'b10, 6'b000000, 3, 4, 0);
        run_req(2'b11, 6'b100000, 3, 4, 1);
        run_req(2'b10, 6'b011010, 55, 0, 0);
        run_req(2'b10, 6'b101010, 32'hFFFF_FFFF, 1, 0);
        reset_abort();

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 9);
            fn  = fn_tab[$urandom_range(0, 5)];
            aop = 2'b10;
            if (k == 0) aop = 2'b11;
            if (k == 1) fn = 6'($urandom);
            if (k == 2) aop = 2'b00;
            if (k == 3) aop = 2'b01;
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 3);
            if (k == 0) b = a;
            if (k == 1) b = 0;
            if (k == 2) b = 32'($urandom_range(1, 9));
            run_req(aop, fn, a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
